// File: rtl/arcade_input_pkg.sv
// Shared scancodes, joystick word layout and direction type
// for the arcade player-input front end.
package arcade_input_pkg;

  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_B0    = 8'h14;
  localparam logic [7:0] SC_P1_B1    = 8'h11;
  localparam logic [7:0] SC_P1_B2    = 8'h29;
  localparam logic [7:0] SC_P1_B3    = 8'h12;
  localparam logic [7:0] SC_P1_START = 8'h16;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E;

  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h23;
  localparam logic [7:0] SC_P2_LEFT  = 8'h2B;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_B0    = 8'h1C;
  localparam logic [7:0] SC_P2_B1    = 8'h1B;
  localparam logic [7:0] SC_P2_B2    = 8'h15;
  localparam logic [7:0] SC_P2_B3    = 8'h1D;
  localparam logic [7:0] SC_P2_START = 8'h1E;
  localparam logic [7:0] SC_P2_COIN  = 8'h36;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;

  function automatic int BTN_IDX(input int b);
    return 4 + b;
  endfunction

  function automatic int START_IDX(input int nb);
    return 4 + nb;
  endfunction

  function automatic int COIN_IDX(input int nb);
    return 5 + nb;
  endfunction

  typedef struct packed {
    logic up;
    logic down;
    logic right;
    logic left;
  } dir_t;

endpackage

// File: rtl/arcade_coin_stretcher.sv
// Turns a coin rising edge into a fixed-length pulse;
// edges during an active pulse are ignored.
module arcade_coin_stretcher #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out
);

  localparam int T  = (TICKS < 1) ? 1 : TICKS;
  localparam int CW = $clog2(T + 1);
  localparam logic [CW-1:0] LOAD = CW'(T);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (in && !prev_q) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= in;
    end
  end

  assign out = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: PS/2 key latches merged with joystick
// words, SOCD cleaning, autofire and coin pulse stretching.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_BUTTONS   = 4,
  parameter int CLK_FREQ_KHZ  = 96000,
  parameter int COIN_PULSE_MS = 50,
  parameter int AUTOFIRE_HZ   = 15,
  parameter int SOCD_NEUTRAL  = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_in,
  input  logic                               joy_merge,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_en,
  output logic [4*NUM_PLAYERS-1:0]           dir,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] buttons,
  output logic [NUM_PLAYERS-1:0]             start,
  output logic [NUM_PLAYERS-1:0]             coin
);

  localparam int NP = NUM_PLAYERS;
  localparam int NB = NUM_BUTTONS;
  localparam int COIN_TICKS = CLK_FREQ_KHZ * COIN_PULSE_MS;
  localparam int AF_HALF = CLK_FREQ_KHZ * 1000 / (2 * AUTOFIRE_HZ);
  localparam int AF_TOP = (AF_HALF > 1) ? AF_HALF - 1 : 0;
  localparam int AFW = (AF_TOP > 0) ? $clog2(AF_TOP + 1) : 1;
  localparam logic [AFW-1:0] AF_LAST = AFW'(AF_TOP);
  localparam int B0 = BTN_IDX(0);
  localparam int SI = START_IDX(NB);
  localparam int CI = COIN_IDX(NB);
  localparam logic SOCD = (SOCD_NEUTRAL != 0);

  logic                 tgl_q;
  logic                 evt;
  logic [7:0]           code;
  logic                 ext;
  logic                 hit;
  int                   kp;
  int                   kb;
  int                   btn;
  logic [NP-1:0][15:0]  key_q, key_d;
  logic [15:0]          joy_or;
  logic [15:0]          jw;
  logic [NP-1:0][15:0]  raw;
  logic [AFW-1:0]       af_cnt_q, af_cnt_d;
  logic                 af_ph_q, af_ph_d;
  logic [4*NP-1:0]      dir_q, dir_d;
  logic [NB*NP-1:0]     btn_q, btn_d;
  logic [NP-1:0]        start_q, start_d;
  dir_t                 d;
  logic                 unused_raw;

  assign code = ps2_key[7:0];
  assign ext  = ps2_key[8];
  assign evt  = ps2_key[10] ^ tgl_q;

  // Direction keys on player 1 live on the extended (arrow) block.
  always_comb begin
    hit = 1'b1;
    kp  = 0;
    kb  = 0;
    btn = -1;
    unique case (1'b1)
      (code == SC_P1_UP    && ext):  kb = JOY_U;
      (code == SC_P1_DOWN  && ext):  kb = JOY_D;
      (code == SC_P1_LEFT  && ext):  kb = JOY_L;
      (code == SC_P1_RIGHT && ext):  kb = JOY_R;
      (code == SC_P1_B0):            btn = 0;
      (code == SC_P1_B1):            btn = 1;
      (code == SC_P1_B2):            btn = 2;
      (code == SC_P1_B3):            btn = 3;
      (code == SC_P1_START):         kb = SI;
      (code == SC_P1_COIN):          kb = CI;
      (code == SC_P2_UP    && !ext): begin kp = 1; kb = JOY_U; end
      (code == SC_P2_DOWN  && !ext): begin kp = 1; kb = JOY_D; end
      (code == SC_P2_LEFT  && !ext): begin kp = 1; kb = JOY_L; end
      (code == SC_P2_RIGHT && !ext): begin kp = 1; kb = JOY_R; end
      (code == SC_P2_B0):            begin kp = 1; btn = 0; end
      (code == SC_P2_B1):            begin kp = 1; btn = 1; end
      (code == SC_P2_B2):            begin kp = 1; btn = 2; end
      (code == SC_P2_B3):            begin kp = 1; btn = 3; end
      (code == SC_P2_START):         begin kp = 1; kb = SI; end
      (code == SC_P2_COIN):          begin kp = 1; kb = CI; end
      default:                       hit = 1'b0;
    endcase
    if (btn >= 0) begin
      kb = BTN_IDX(btn);
      if (btn >= NB) hit = 1'b0;
    end
  end

  always_comb begin
    key_d = key_q;
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < 16; b++) begin
        if (evt && hit && p == kp && b == kb) begin
          key_d[p][b] = ps2_key[9];
        end
      end
    end
  end

  always_comb begin
    joy_or = '0;
    jw     = '0;
    raw    = '0;
    for (int p = 0; p < NP; p++) begin
      joy_or = joy_or | joy_in[16*p +: 16];
    end
    for (int p = 0; p < NP; p++) begin
      if (joy_merge) begin
        jw = (p == 0) ? joy_or : 16'h0000;
      end else begin
        jw = joy_in[16*p +: 16];
      end
      raw[p] = key_q[p] | jw;
    end
  end

  always_comb begin
    af_cnt_d = af_cnt_q + 1'b1;
    af_ph_d  = af_ph_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d = '0;
      af_ph_d  = ~af_ph_q;
    end
  end

  always_comb begin
    dir_d   = '0;
    btn_d   = '0;
    start_d = '0;
    d       = '0;
    for (int p = 0; p < NP; p++) begin
      d.up    = raw[p][JOY_U] & ~(SOCD & raw[p][JOY_D]);
      d.down  = raw[p][JOY_D] & ~(SOCD & raw[p][JOY_U]);
      d.right = raw[p][JOY_R] & ~(SOCD & raw[p][JOY_L]);
      d.left  = raw[p][JOY_L] & ~(SOCD & raw[p][JOY_R]);
      dir_d[4*p +: 4] = d;
      for (int b = 0; b < NB; b++) begin
        btn_d[NB*p + b] = raw[p][B0 + b] &
                          (~autofire_en[NB*p + b] | af_ph_q);
      end
      start_d[p] = raw[p][SI];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tgl_q    <= ps2_key[10];
      key_q    <= '0;
      af_cnt_q <= '0;
      af_ph_q  <= 1'b1;
      dir_q    <= '0;
      btn_q    <= '0;
      start_q  <= '0;
    end else begin
      tgl_q    <= ps2_key[10];
      key_q    <= key_d;
      af_cnt_q <= af_cnt_d;
      af_ph_q  <= af_ph_d;
      dir_q    <= dir_d;
      btn_q    <= btn_d;
      start_q  <= start_d;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_coin
    arcade_coin_stretcher #(
      .TICKS(COIN_TICKS)
    ) u_coin (
      .clk    (clk),
      .reset_n(reset_n),
      .in     (raw[p][CI]),
      .out    (coin[p])
    );
  end

  assign dir        = dir_q;
  assign buttons    = btn_q;
  assign start      = start_q;
  assign unused_raw = ^raw;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl at reduced timing
// (4-tick coin pulse, 4-tick autofire half period).
module tb_arcade_input_ctrl;

  localparam int NP = 2;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [10:0]       ps2_key;
  logic [16*NP-1:0]  joy_in;
  logic              joy_merge;
  logic [NP*NB-1:0]  af_en;
  logic [4*NP-1:0]   dir;
  logic [NB*NP-1:0]  buttons;
  logic [NP-1:0]     start;
  logic [NP-1:0]     coin;

  int checks = 0;
  int failures = 0;
  int hi;
  int rises;
  int ones;
  int bad;
  logic prev;
  logic [15:0] s;

  arcade_input_ctrl #(
    .NUM_PLAYERS  (NP),
    .NUM_BUTTONS  (NB),
    .CLK_FREQ_KHZ (1),
    .COIN_PULSE_MS(4),
    .AUTOFIRE_HZ  (125),
    .SOCD_NEUTRAL (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joy_in     (joy_in),
    .joy_merge  (joy_merge),
    .autofire_en(af_en),
    .dir        (dir),
    .buttons    (buttons),
    .start      (start),
    .coin       (coin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2(input logic pr, input logic ex, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], pr, ex, sc};
  endtask

  initial begin
    ps2_key   = '0;
    joy_in    = '0;
    joy_merge = 1'b0;
    af_en     = '0;
    reset_n   = 1'b0;
    tick(2);
    chk("reset_out", 32'({dir, buttons, start, coin}), 0);
    reset_n = 1'b1;
    tick(1);

    ps2(1'b1, 1'b1, 8'h75);
    tick(1);
    chk("p1_up_lat1", 32'(dir[3]), 0);
    tick(1);
    chk("p1_up_on", 32'(dir[3]), 1);
    ps2(1'b0, 1'b1, 8'h75);
    tick(2);
    chk("p1_up_off", 32'(dir[3]), 0);
    ps2(1'b1, 1'b0, 8'h75);
    tick(3);
    chk("kp8_ignored", 32'(dir), 0);
    ps2(1'b0, 1'b0, 8'h75);
    tick(1);

    ps2(1'b1, 1'b0, 8'h1C);
    tick(2);
    chk("p2_b0_on", 32'(buttons), 32'h10);
    ps2(1'b0, 1'b0, 8'h1C);
    tick(2);
    chk("p2_b0_off", 32'(buttons), 0);

    joy_in = {16'h0000, 16'h000C};
    tick(1);
    chk("socd_ud", 32'(dir), 0);
    joy_in = {16'h0000, 16'h0001};
    tick(1);
    chk("joy_right", 32'(dir), 32'h02);
    joy_in = {16'h0003, 16'h000A};
    tick(1);
    chk("socd_lr_ul", 32'(dir), 32'h09);
    joy_in = {16'h0100, 16'h0000};
    tick(1);
    chk("start_p2", 32'(start), 32'h2);
    joy_in = '0;
    tick(1);

    ps2(1'b1, 1'b0, 8'h2E);
    hi = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (coin[0]) hi++;
      if (coin[0] && !prev) rises++;
      prev = coin[0];
      if (i == 19) ps2(1'b0, 1'b0, 8'h2E);
    end
    chk("coin_len", 32'(hi), 4);
    chk("coin_single", 32'(rises), 1);

    joy_in = {16'h0000, 16'h0200};
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (coin[0]) hi++;
      if (i == 1) joy_in = '0;
      if (i == 2) joy_in = {16'h0000, 16'h0200};
    end
    chk("coin_no_ext", 32'(hi), 4);
    joy_in = '0;
    tick(2);

    af_en  = 8'h01;
    joy_in = {16'h0000, 16'h0010};
    tick(1);
    s = '0;
    ones = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      s[i] = buttons[0];
      if (buttons[0]) ones++;
    end
    for (int i = 0; i < 12; i++) begin
      if (s[i+4] == s[i]) bad++;
    end
    chk("af_duty", 32'(ones), 8);
    chk("af_period", 32'(bad), 0);
    af_en = '0;
    tick(1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (buttons[0]) ones++;
    end
    chk("af_off_steady", 32'(ones), 8);
    joy_in = '0;
    tick(1);

    joy_merge = 1'b1;
    joy_in = {16'h0010, 16'h0000};
    tick(1);
    chk("merge_p1b0", 32'(buttons[0]), 1);
    chk("merge_p2b0", 32'(buttons[NB]), 0);
    joy_in = {16'h0011, 16'h0000};
    tick(1);
    chk("merge_dir", 32'(dir), 32'h02);
    joy_merge = 1'b0;
    joy_in = '0;
    tick(2);

    af_en  = 8'h01;
    joy_in = {16'h0000, 16'h0210};
    tick(2);
    chk("pre_reset_coin", 32'(coin[0]), 1);
    reset_n = 1'b0;
    tick(1);
    chk("reset_mid", 32'({dir, buttons, start, coin}), 0);
    joy_in = '0;
    af_en  = '0;
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h75};
    tick(1);
    reset_n = 1'b1;
    tick(4);
    chk("no_evt_after_rst", 32'({dir, buttons, start, coin}), 0);
    ps2(1'b1, 1'b1, 8'h75);
    tick(2);
    chk("evt_after_rst", 32'(dir[3]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
